i2c_txn_arbiter: RTL

Shares one I2C master engine between NUM_REQ independent requesters (sensor pollers, config loaders, debug port). Each requester hands over a complete register transaction: slave address, register address, write data and direction. The arbiter picks requests round-robin, launches each one on the master and supervises it with a timeout. It then returns completion status and read data to the requester that issued it. It sits directly above the I2C master and is the only block that drives the master's command inputs.

---
 rtl/i2c_pkg.sv | 24 ++
 rtl/i2c_rr_pick.sv | 30 +++
 rtl/i2c_txn_arbiter.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/i2c_pkg.sv
// i2c_pkg: shared definitions for the I2C transaction arbiter.
//   - field widths of an I2C register transaction
//   - response status codes returned to requesters
//   - arbiter FSM state encoding
package i2c_pkg;

    localparam int I2C_ADDR_W = 7;
    localparam int I2C_REG_W  = 8;
    localparam int I2C_DATA_W = 8;

    localparam logic [1:0] STAT_OK      = 2'b00;
    localparam logic [1:0] STAT_NACK    = 2'b01;
    localparam logic [1:0] STAT_TIMEOUT = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GRANT,
        ST_LAUNCH,
        ST_WAIT,
        ST_RESP,
        ST_GAP
    } arb_state_t;

endpackage

// File: rtl/i2c_rr_pick.sv
// i2c_rr_pick: combinational round-robin picker.
//   req  : request vector, one bit per requester
//   ptr  : index with highest priority this round
//   any  : at least one request is asserted
//   idx  : first asserted index at or after ptr, wrapping modulo NUM_REQ
module i2c_rr_pick #(
    parameter int NUM_REQ = 4,
    localparam int IDX_W = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic               any,
    output logic [IDX_W-1:0]   idx
);

    always_comb begin
        int j;
        j   = 0;
        any = 1'b0;
        idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = (int'(ptr) + k) % NUM_REQ;
            if (!any && req[j]) begin
                any = 1'b1;
                idx = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/i2c_txn_arbiter.sv
// i2c_txn_arbiter: shares one I2C master between NUM_REQ requesters.
//   clk, reset                 : clock, synchronous active-high reset
//   req_valid/req_ready        : per-requester request handshake (ready is one-hot)
//   req_slave_addr/reg_addr/wdata/rw : packed per-requester transaction fields
//   rsp_valid/rsp_status/rsp_rdata   : one-hot completion pulse with result
//   m_start/m_abort            : launch and abort pulses to the master
//   m_slave_addr/reg_addr/wdata/rw   : latched fields for the current transaction
//   m_done/m_nack/m_rdata      : master completion inputs
//   grant_id, busy             : current owner index, arbiter not idle
module i2c_txn_arbiter
    import i2c_pkg::*;
#(
    parameter int NUM_REQ         = 4,
    parameter int TIMEOUT_CYCLES  = 4096,
    parameter int BUS_FREE_CYCLES = 8,
    localparam int IDX_W = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [I2C_ADDR_W*NUM_REQ-1:0] req_slave_addr,
    input  logic [I2C_REG_W*NUM_REQ-1:0]  req_reg_addr,
    input  logic [I2C_DATA_W*NUM_REQ-1:0] req_wdata,
    input  logic [NUM_REQ-1:0]            req_rw,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [1:0]                    rsp_status,
    output logic [I2C_DATA_W-1:0]         rsp_rdata,
    output logic                          m_start,
    output logic [I2C_ADDR_W-1:0]         m_slave_addr,
    output logic [I2C_REG_W-1:0]          m_reg_addr,
    output logic [I2C_DATA_W-1:0]         m_wdata,
    output logic                          m_rw,
    output logic                          m_abort,
    input  logic                          m_done,
    input  logic                          m_nack,
    input  logic [I2C_DATA_W-1:0]         m_rdata,
    output logic [IDX_W-1:0]              grant_id,
    output logic                          busy
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam int GAP_W = (BUS_FREE_CYCLES > 1) ? $clog2(BUS_FREE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(BUS_FREE_CYCLES - 1);

    arb_state_t        state, next_state;
    logic [IDX_W-1:0]  rr_ptr;
    logic [CNT_W-1:0]  to_cnt;
    logic [GAP_W-1:0]  gap_cnt;
    logic              pick_any;
    logic [IDX_W-1:0]  pick_idx;

    i2c_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req (req_valid),
        .ptr (rr_ptr),
        .any (pick_any),
        .idx (pick_idx)
    );

    always_comb begin
        next_state = state;
        req_ready  = '0;
        rsp_valid  = '0;
        m_start    = 1'b0;
        m_abort    = 1'b0;
        case (state)
            ST_IDLE:   if (pick_any) next_state = ST_GRANT;
            ST_GRANT: begin
                // A requester that withdrew before acceptance is simply skipped.
                if (req_valid[grant_id]) begin
                    req_ready[grant_id] = 1'b1;
                    next_state          = ST_LAUNCH;
                end else begin
                    next_state = ST_IDLE;
                end
            end
            ST_LAUNCH: begin
                m_start    = 1'b1;
                next_state = ST_WAIT;
            end
            ST_WAIT: begin
                // m_done takes priority over a coincident timeout.
                if (m_done) begin
                    next_state = ST_RESP;
                end else if (to_cnt == TO_LAST) begin
                    m_abort    = 1'b1;
                    next_state = ST_RESP;
                end
            end
            ST_RESP: begin
                rsp_valid[grant_id] = 1'b1;
                next_state          = ST_GAP;
            end
            ST_GAP:    if (gap_cnt == GAP_LAST) next_state = ST_IDLE;
            default:   next_state = ST_IDLE;
        endcase
    end

    assign busy = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            rr_ptr       <= '0;
            grant_id     <= '0;
            to_cnt       <= '0;
            gap_cnt      <= '0;
            rsp_status   <= STAT_OK;
            rsp_rdata    <= '0;
            m_slave_addr <= '0;
            m_reg_addr   <= '0;
            m_wdata      <= '0;
            m_rw         <= 1'b0;
        end else begin
            state <= next_state;
            case (state)
                ST_IDLE: if (pick_any) grant_id <= pick_idx;
                ST_GRANT: begin
                    if (req_valid[grant_id]) begin
                        m_slave_addr <= req_slave_addr[int'(grant_id)*I2C_ADDR_W +: I2C_ADDR_W];
                        m_reg_addr   <= req_reg_addr[int'(grant_id)*I2C_REG_W +: I2C_REG_W];
                        m_wdata      <= req_wdata[int'(grant_id)*I2C_DATA_W +: I2C_DATA_W];
                        m_rw         <= req_rw[grant_id];
                        rr_ptr       <= (grant_id == IDX_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
                    end
                end
                ST_LAUNCH: to_cnt <= '0;
                ST_WAIT: begin
                    to_cnt <= to_cnt + 1'b1;
                    if (m_done) begin
                        rsp_status <= m_nack ? STAT_NACK : STAT_OK;
                        rsp_rdata  <= (!m_nack && m_rw) ? m_rdata : '0;
                    end else if (to_cnt == TO_LAST) begin
                        rsp_status <= STAT_TIMEOUT;
                        rsp_rdata  <= '0;
                    end
                end
                ST_RESP: gap_cnt <= '0;
                ST_GAP:  gap_cnt <= gap_cnt + 1'b1;
                default: ;
            endcase
        end
    end

endmodule
